dmem_unit: RTL and testbench

Data-memory unit serving the MEM stage's data-memory port. It takes the stage's address, read/write control, access type and store data, and returns formatted load data to the MEM/WB flow. It holds a word-wide synchronous-read RAM that accepts sub-word stores through byte enables. A load needs one wait cycle, so the unit raises a stall to the hazard logic for that cycle. Misaligned accesses are flagged and suppressed.

---
 rtl/dmem_unit.sv | 161 ++++++++++++++++
 tb/tb_dmem_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_unit.sv
// Data-memory unit for the MEM stage: word-wide synchronous-read RAM with byte-enable stores,
// a two-state load FSM that stalls one cycle, and misaligned/illegal access suppression.
module dmem_unit #(
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        MemRW,
  input  logic [2:0]  RWType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] hold_q, hold_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;

  logic [AW-1:0] idx_s;
  logic          legal_s;
  logic          rd_en_s;
  logic [3:0]    we_s;
  logic [31:0]   wd_s;
  logic [31:0]   load_s;
  logic          unused_addr_s;

  // Selects the addressed byte/half of the RAM word and extends it per access type.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] t,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = w;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign idx_s         = addr[AW+1:2];
  assign unused_addr_s = ^addr[31:AW+2];
  assign load_s        = fmt_load(ram_q, type_q, off_q);

  // Access-type legality and alignment check.
  always_comb begin
    legal_s = 1'b0;
    case (RWType)
      3'b000, 3'b100: legal_s = 1'b1;
      3'b001, 3'b101: legal_s = ~addr[0];
      3'b010:         legal_s = (addr[1:0] == 2'b00);
      default:        legal_s = 1'b0;
    endcase
  end

  // Load FSM next state, store byte enables and output formatting.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    off_d   = off_q;
    hold_d  = hold_q;
    stall   = 1'b0;
    fault   = 1'b0;
    rd_en_s = 1'b0;
    we_s    = 4'b0000;
    wd_s    = wdata;
    rdata   = hold_q;
    case (state_q)
      S_IDLE: begin
        // Requests presented while reset is asserted are dropped entirely.
        if (rstn && req) begin
          if (!legal_s) begin
            fault = 1'b1;
            rdata = 32'h0000_0000;
          end else if (MemRW) begin
            case (RWType[1:0])
              2'b00: begin
                we_s = 4'b0001 << addr[1:0];
                wd_s = {4{wdata[7:0]}};
              end
              2'b01: begin
                we_s = 4'b0011 << addr[1:0];
                wd_s = {2{wdata[15:0]}};
              end
              default: begin
                we_s = 4'b1111;
                wd_s = wdata;
              end
            endcase
          end else begin
            stall   = 1'b1;
            rd_en_s = 1'b1;
            type_d  = RWType;
            off_d   = addr[1:0];
            state_d = S_WAIT;
          end
        end else begin
          rdata = hold_q;
        end
      end
      S_WAIT: begin
        rdata   = load_s;
        hold_d  = load_s;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      type_q  <= 3'b000;
      off_q   <= 2'b00;
      hold_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      off_q   <= off_d;
      hold_q  <= hold_d;
    end
  end

  // RAM array: byte-enable write and registered read; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_s[b]) begin
        mem[idx_s][8*b +: 8] <= wd_s[8*b +: 8];
      end
    end
    if (rd_en_s) begin
      ram_q <= mem[idx_s];
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Directed self-checking bench for dmem_unit: reset, word/sub-word round trips,
// misalignment suppression, reset during a load, store-to-load ordering and address wrap.
module tb_dmem_unit;

  logic        clk;
  logic        rstn;
  logic        req;
  logic        MemRW;
  logic [2:0]  RWType;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;

  int checks;
  int errors;

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  dmem_unit #(.DEPTH(4096), .INIT_FILE("")) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .MemRW  (MemRW),
    .RWType (RWType),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .stall  (stall),
    .fault  (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled 2 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    cyc();
    req = 1'b1; MemRW = 1'b1; RWType = t; addr = a; wdata = d;
    #2;
    chk("st_stall", {31'd0, stall}, 32'd0);
    chk("st_fault", {31'd0, fault}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] exp_v);
    cyc();
    req = 1'b1; MemRW = 1'b0; RWType = t; addr = a; wdata = 32'h0;
    #2;
    chk({tag, "_stall1"}, {31'd0, stall}, 32'd1);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    cyc();
    #2;
    chk({tag, "_stall0"}, {31'd0, stall}, 32'd0);
    chk({tag, "_data"}, rdata, exp_v);
    cyc();
    req = 1'b0;
    #2;
    chk({tag, "_hold"}, rdata, exp_v);
  endtask

  task automatic do_fault(input string tag, input logic rw, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d);
    cyc();
    req = 1'b1; MemRW = rw; RWType = t; addr = a; wdata = d;
    #2;
    chk({tag, "_fault"}, {31'd0, fault}, 32'd1);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got %0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0; req = 1'b1; MemRW = 1'b0; RWType = T_W; addr = 32'h10; wdata = 32'h0;

    for (int i = 0; i < 2; i++) begin
      cyc();
      #2;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end
    cyc();
    rstn = 1'b1; req = 1'b0;
    #2;
    chk("post_rst_rdata", rdata, 32'd0);

    do_store(T_W, 32'h10, 32'hDEADBEEF);
    do_load("lw10", T_W, 32'h10, 32'hDEADBEEF);

    do_store(T_B, 32'h11, 32'h12345680);
    do_load("lb11", T_B, 32'h11, 32'hFFFFFF80);
    do_load("lbu11", T_BU, 32'h11, 32'h00000080);
    do_load("lh12", T_H, 32'h12, 32'hFFFFDEAD);
    do_load("lhu10", T_HU, 32'h10, 32'h000080EF);
    do_load("lw10b", T_W, 32'h10, 32'hDEAD80EF);

    do_fault("lw13", 1'b0, T_W, 32'h13, 32'h0);
    do_fault("sh11", 1'b1, T_H, 32'h11, 32'h0000FFFF);
    do_fault("ill3", 1'b0, 3'b011, 32'h10, 32'h0);
    do_load("lw10c", T_W, 32'h10, 32'hDEAD80EF);

    cyc();
    req = 1'b0; MemRW = 1'b1; RWType = 3'b111; addr = 32'h13;
    #2;
    chk("noreq_fault", {31'd0, fault}, 32'd0);
    chk("noreq_stall", {31'd0, stall}, 32'd0);

    do_store(T_B, 32'h13, 32'hAAAAAA55);
    do_load("lb13", T_B, 32'h13, 32'h00000055);
    do_store(T_H, 32'h12, 32'h0000BEEF);
    do_load("lw10d", T_W, 32'h10, 32'hBEEF80EF);

    cyc();
    req = 1'b1; MemRW = 1'b0; RWType = T_W; addr = 32'h10;
    #2;
    chk("rw_stall1", {31'd0, stall}, 32'd1);
    cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1; req = 1'b0;
    #2;
    chk("rw_rdata", rdata, 32'd0);
    chk("rw_stall", {31'd0, stall}, 32'd0);
    do_load("rw_fresh", T_W, 32'h10, 32'hBEEF80EF);

    do_store(T_W, 32'h20, 32'h12345678);
    do_load("fwd20", T_W, 32'h20, 32'h12345678);

    do_load("wrap", T_W, 32'h10 + 32'h4000, 32'hBEEF80EF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
